// File: rtl/frame_streamer.sv
// Captures a parallel 2-D frame into an internal buffer and re-emits it as a
// raster-order valid/ready pixel stream with SOF/EOL/EOF markers.
module frame_streamer #(
  parameter int unsigned HEIGHT      = 50,
  parameter int unsigned WIDTH       = 50,
  parameter int unsigned PIXEL_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [PIXEL_WIDTH-1:0] frame_in [HEIGHT-1:0][WIDTH-1:0],
  input  logic                   frame_in_valid,
  output logic                   frame_in_ready,
  output logic [PIXEL_WIDTH-1:0] m_pixel,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic                   m_sof,
  output logic                   m_eol,
  output logic                   m_eof,
  output logic [15:0]            frame_count,
  output logic [15:0]            dropped_frames
);

  localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                 state;
  logic [PIXEL_WIDTH-1:0] buffer [HEIGHT-1:0][WIDTH-1:0];
  logic [ROW_W-1:0]       row;
  logic [COL_W-1:0]       col;
  logic [ROW_W-1:0]       next_row_c;
  logic [COL_W-1:0]       next_col_c;
  logic [PIXEL_WIDTH-1:0] next_pixel_c;
  logic                   valid_prev;
  logic                   start_c;
  logic                   fire_c;
  logic                   last_c;

  assign start_c = frame_in_valid && !valid_prev;
  assign fire_c  = m_valid && m_ready;
  assign last_c  = (row == LAST_ROW) && (col == LAST_COL);

  // Raster position following the current beat
  always_comb begin
    next_col_c = col + 1'b1;
    next_row_c = row;
    if (col == LAST_COL) begin
      next_col_c = '0;
      next_row_c = row + 1'b1;
    end
  end

  // Select-by-compare lookup keeps every index constant and in range
  always_comb begin
    next_pixel_c = '0;
    for (int unsigned r = 0; r < HEIGHT; r++) begin
      for (int unsigned c = 0; c < WIDTH; c++) begin
        if (next_row_c == ROW_W'(r) && next_col_c == COL_W'(c)) begin
          next_pixel_c = buffer[r][c];
        end
      end
    end
  end

  // Frame buffer has no reset; it is only read after a capture
  always_ff @(posedge clk) begin
    if (!reset && state == IDLE && start_c) begin
      buffer <= frame_in;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      row            <= '0;
      col            <= '0;
      valid_prev     <= 1'b0;
      frame_in_ready <= 1'b1;
      m_valid        <= 1'b0;
      m_pixel        <= '0;
      m_sof          <= 1'b0;
      m_eol          <= 1'b0;
      m_eof          <= 1'b0;
      frame_count    <= '0;
      dropped_frames <= '0;
    end else begin
      valid_prev <= frame_in_valid;
      case (state)
        IDLE: begin
          if (start_c) begin
            state          <= STREAM;
            row            <= '0;
            col            <= '0;
            frame_in_ready <= 1'b0;
            m_valid        <= 1'b1;
            m_pixel        <= frame_in[0][0];
            m_sof          <= 1'b1;
            m_eol          <= (WIDTH == 1);
            m_eof          <= (WIDTH == 1) && (HEIGHT == 1);
          end
        end
        STREAM: begin
          if (start_c && dropped_frames != 16'hFFFF) begin
            dropped_frames <= dropped_frames + 16'd1;
          end
          if (fire_c) begin
            if (last_c) begin
              state          <= IDLE;
              frame_in_ready <= 1'b1;
              m_valid        <= 1'b0;
              m_sof          <= 1'b0;
              m_eol          <= 1'b0;
              m_eof          <= 1'b0;
              frame_count    <= frame_count + 16'd1;
            end else begin
              row     <= next_row_c;
              col     <= next_col_c;
              m_pixel <= next_pixel_c;
              m_sof   <= 1'b0;
              m_eol   <= (next_col_c == LAST_COL);
              m_eof   <= (next_row_c == LAST_ROW) && (next_col_c == LAST_COL);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_frame_streamer.sv
// Scoreboard bench for frame_streamer: a transaction-level model predicts the
// beat stream and counters; a separate monitor checks every accepted beat.
module tb_frame_streamer;

  localparam int H = 3;
  localparam int W = 4;

  typedef struct packed {
    logic [7:0] pix;
    logic       sof;
    logic       eol;
    logic       eof;
  } beat_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  fin [H-1:0][W-1:0];
  logic        fiv = 1'b0;
  logic        fir;
  logic [7:0]  pix;
  logic        mv;
  logic        mr = 1'b0;
  logic        sof, eol, eof;
  logic [15:0] fcnt, dcnt;

  logic [7:0]  fin1 [0:0][0:0];
  logic        fiv1 = 1'b0;
  logic        fir1;
  logic [7:0]  pix1;
  logic        mv1;
  logic        mr1 = 1'b1;
  logic        sof1, eol1, eof1;
  logic [15:0] fcnt1, dcnt1;

  int total = 0;
  int bad   = 0;

  beat_t       exp_q[$];
  int          remaining = 0;
  logic [15:0] exp_cnt = '0;
  logic [15:0] exp_drop = '0;
  logic        prev_v = 1'b0;
  int          beats = 0;

  always #5 clk = ~clk;

  frame_streamer #(.HEIGHT(H), .WIDTH(W), .PIXEL_WIDTH(8)) dut (
    .clk(clk), .reset(rst), .frame_in(fin), .frame_in_valid(fiv),
    .frame_in_ready(fir), .m_pixel(pix), .m_valid(mv), .m_ready(mr),
    .m_sof(sof), .m_eol(eol), .m_eof(eof),
    .frame_count(fcnt), .dropped_frames(dcnt)
  );

  frame_streamer #(.HEIGHT(1), .WIDTH(1), .PIXEL_WIDTH(8)) dut1 (
    .clk(clk), .reset(rst), .frame_in(fin1), .frame_in_valid(fiv1),
    .frame_in_ready(fir1), .m_pixel(pix1), .m_valid(mv1), .m_ready(mr1),
    .m_sof(sof1), .m_eol(eol1), .m_eof(eof1),
    .frame_count(fcnt1), .dropped_frames(dcnt1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: evaluated mid-cycle for the upcoming rising edge
  always @(negedge clk) begin
    beat_t b;
    logic  start;
    if (rst) begin
      remaining = 0;
      exp_q.delete();
      exp_cnt  = '0;
      exp_drop = '0;
      prev_v   = 1'b0;
    end else begin
      chk("m_valid_level", 32'(mv), 32'(remaining > 0));
      chk("ready_level", 32'(fir), 32'(remaining == 0));
      start = fiv && !prev_v;
      if (remaining == 0) begin
        if (start) begin
          for (int r = 0; r < H; r++) begin
            for (int c = 0; c < W; c++) begin
              b.pix = fin[r][c];
              b.sof = (r == 0) && (c == 0);
              b.eol = (c == W - 1);
              b.eof = (r == H - 1) && (c == W - 1);
              exp_q.push_back(b);
            end
          end
          remaining = H * W;
        end
      end else begin
        if (start && exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
        if (mr) begin
          remaining--;
          if (remaining == 0) exp_cnt = exp_cnt + 16'd1;
        end
      end
      prev_v = fiv;
    end
  end

  // Monitor: stall stability and accepted-beat scoreboard
  logic  hold = 1'b0;
  beat_t held;
  always @(negedge clk) begin
    beat_t got;
    beat_t want;
    got = '{pix: pix, sof: sof, eol: eol, eof: eof};
    if (rst) begin
      hold = 1'b0;
    end else begin
      if (hold) begin
        chk("stall_valid", 32'(mv), 32'd1);
        chk("stall_beat", 32'(got), 32'(held));
      end
      hold = mv && !mr;
      held = got;
      if (mv && mr) begin
        beats++;
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", 32'(got), 32'hFFFF_FFFF);
        end else begin
          want = exp_q.pop_front();
          chk("beat", 32'(got), 32'(want));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_ramp();
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) fin[r][c] = 8'(16 * r + c);
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 300 && remaining > 0; k++) tick();
    chk("idle_timeout", 32'(remaining), 32'd0);
    tick();
  endtask

  task automatic pulse();
    fiv = 1'b1;
    tick();
    fiv = 1'b0;
  endtask

  initial begin
    int base;
    fill_ramp();
    fin1[0][0] = 8'hAB;
    rst = 1'b1;
    repeat (3) tick();
    chk("rst_ready", 32'(fir), 32'd1);
    chk("rst_valid", 32'(mv), 32'd0);
    chk("rst_pixel", 32'(pix), 32'd0);
    chk("rst_flags", 32'({sof, eol, eof}), 32'd0);
    chk("rst_fcnt", 32'(fcnt), 32'd0);
    chk("rst_drop", 32'(dcnt), 32'd0);
    rst = 1'b0;
    tick();

    // Ramp frame, always ready
    mr = 1'b1;
    pulse();
    chk("first_beat_pix", 32'(pix), 32'h00);
    chk("first_beat_sof", 32'(sof), 32'd1);
    wait_idle();
    chk("fcnt_after_1", 32'(fcnt), 32'd1);
    chk("ready_after_1", 32'(fir), 32'd1);

    // Random frames, random backpressure, frame_in churned during streaming
    for (int f = 0; f < 3; f++) begin
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) fin[r][c] = 8'($urandom);
      mr = 1'($urandom_range(0, 1));
      pulse();
      for (int k = 0; k < 300 && remaining > 0; k++) begin
        mr = 1'($urandom_range(0, 1));
        fin[$urandom_range(0, H - 1)][$urandom_range(0, W - 1)] = 8'($urandom);
        tick();
      end
      chk("rand_timeout", 32'(remaining), 32'd0);
      tick();
      chk("rand_fcnt", 32'(fcnt), 32'(exp_cnt));
    end
    mr = 1'b1;

    // Valid held high for 40 cycles: one frame, no drops
    fill_ramp();
    fiv = 1'b1;
    repeat (40) tick();
    fiv = 1'b0;
    wait_idle();
    chk("held_fcnt", 32'(fcnt), 32'd5);
    chk("held_drop", 32'(dcnt), 32'd0);

    // Drops mid-frame and on the final handshake edge
    pulse();
    base = beats;
    for (int k = 0; k < 100 && beats < base + 4; k++) tick();
    pulse();
    for (int k = 0; k < 100 && remaining != 1; k++) tick();
    pulse();
    wait_idle();
    repeat (3) tick();
    chk("drop_count", 32'(dcnt), 32'd2);
    chk("drop_model", 32'(dcnt), 32'(exp_drop));
    chk("drop_fcnt", 32'(fcnt), 32'd6);
    chk("drop_ready", 32'(fir), 32'd1);
    chk("drop_no_frame", 32'(mv), 32'd0);

    // Reset mid-stream
    pulse();
    base = beats;
    for (int k = 0; k < 100 && beats < base + 5; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(mv), 32'd0);
    chk("mid_rst_flags", 32'({sof, eol, eof}), 32'd0);
    chk("mid_rst_fcnt", 32'(fcnt), 32'd0);
    chk("mid_rst_ready", 32'(fir), 32'd1);
    tick();
    pulse();
    chk("restart_pix", 32'(pix), 32'h00);
    chk("restart_sof", 32'(sof), 32'd1);
    wait_idle();
    chk("restart_fcnt", 32'(fcnt), 32'd1);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    // 1x1 frame: single beat carrying every marker
    fiv1 = 1'b1;
    tick();
    fiv1 = 1'b0;
    chk("one_valid", 32'(mv1), 32'd1);
    chk("one_pix", 32'(pix1), 32'hAB);
    chk("one_flags", 32'({sof1, eol1, eof1}), 32'h7);
    chk("one_ready_busy", 32'(fir1), 32'd0);
    tick();
    chk("one_done_valid", 32'(mv1), 32'd0);
    chk("one_done_flags", 32'({sof1, eol1, eof1}), 32'd0);
    chk("one_fcnt", 32'(fcnt1), 32'd1);
    chk("one_pix_hold", 32'(pix1), 32'hAB);
    chk("one_ready", 32'(fir1), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/frame_streamer.md
Name: frame_streamer

Overview:
- Consumer at the output end of the edge-detection pipeline.
- Captures a complete processed frame, presented as a parallel 2-D pixel array with a valid flag, into an internal frame buffer.
- Re-emits the frame as a raster-order pixel stream with valid/ready backpressure and start-of-frame, end-of-line and end-of-frame markers, for downstream DMA/display logic.
- Counts streamed frames and counts frames dropped while busy.

Parameters:
HEIGHT, 50, frame rows.
WIDTH, 50, frame columns.
PIXEL_WIDTH, 8, bits per pixel.

Ports:
clk  input  1  system clock; all logic on rising edge.
reset  input  1  synchronous, active-high reset.
frame_in  input  PIXEL_WIDTH x [HEIGHT-1:0][WIDTH-1:0]  unpacked parallel frame; index [row][col].
frame_in_valid  input  1  frame_in holds a finished frame; may stay high for many cycles.
frame_in_ready  output  1  high when in IDLE and able to capture.
m_pixel  output  PIXEL_WIDTH  current stream pixel.
m_valid  output  1  m_pixel and the marker flags are valid.
m_ready  input  1  downstream accepts the current beat.
m_sof  output  1  beat is pixel [0][0].
m_eol  output  1  beat is the last column of a row.
m_eof  output  1  beat is pixel [HEIGHT-1][WIDTH-1].
frame_count  output  16  frames fully streamed; wraps 0xFFFF to 0.
dropped_frames  output  16  frame starts ignored while busy; saturates at 0xFFFF.

Behaviour:
- Reset values: frame_in_ready=1, m_valid=0, m_pixel=0, m_sof=m_eol=m_eof=0, frame_count=0, dropped_frames=0, row=col=0, state=IDLE, valid_prev=0. Buffer contents are don't-care.
- Frame start: rising edge of frame_in_valid, i.e. frame_in_valid=1 and valid_prev=0. valid_prev registers frame_in_valid every cycle, including while busy.
- A valid held high after release from reset counts as a start on the first post-reset cycle.
- States: IDLE and STREAM, both registered.
- IDLE:
  - On a frame start, copy all of frame_in into the buffer at that edge.
  - Set row=col=0 and go to STREAM.
  - On that same edge: frame_in_ready=0, m_valid=1, m_pixel=frame_in[0][0], m_sof=1, m_eol=(WIDTH==1), m_eof=(WIDTH==1 && HEIGHT==1).
  - Capture-to-first-beat latency is 1 cycle.
- STREAM:
  - Handshake is m_valid && m_ready at a clock edge.
  - No handshake: all m_* outputs hold stable. m_ready is sampled only while m_valid=1.
  - Handshake, not last pixel: advance col. If col==WIDTH-1, set col=0 and row=row+1. Present the next buffered pixel and its flags on the same edge, giving 1 beat per clock with m_ready held high.
  - m_sof is high only for [0][0]. m_eol is high when col==WIDTH-1. m_eof is high only at the last pixel.
  - Handshake on the last pixel: m_valid=0, flags=0, m_pixel holds its value, frame_count+1, state=IDLE, frame_in_ready=1, all on that edge.
  - Streaming one full frame with m_ready constantly high takes exactly HEIGHT*WIDTH cycles of m_valid.
- Drops: a frame start while state=STREAM, including the cycle of the final handshake, is ignored and increments dropped_frames (saturating). The frame is not queued.
- frame_in is sampled only on the capture edge. Later changes to frame_in do not affect the frame being streamed.
- Reset mid-stream: returns to reset values on the next edge. The partial frame is discarded; frame_count does not increment.
- Buffer is an internal register/RAM copy. Index arithmetic uses $clog2(HEIGHT) and $clog2(WIDTH) bit counters; no out-of-range index is ever formed.

Test Plan:
- HEIGHT=3, WIDTH=4, frame_in[r][c]=16*r+c, m_ready=1, one-cycle valid pulse at cycle T. Required: m_valid high cycles T+1..T+12; pixels 0x00,01,02,03,10,11,12,13,20,21,22,23; m_sof on beat 1; m_eol on beats 4, 8, 12; m_eof on beat 12; frame_count=1; frame_in_ready=1 from T+13.
- Same frame, m_ready toggled 1,0,0,1,... pseudo-randomly. Required: m_pixel and flags stable across every stall; same 12-pixel sequence; no duplicated or skipped beats.
- frame_in_valid held high for 40 cycles. Required: exactly one frame streamed; dropped_frames=0, since there is no second rising edge.
- Second valid pulse at beat 5, and a third pulse on the final-handshake cycle. Required: dropped_frames=2; frame_in_ready=1 after beat 12; no second frame streamed.
- reset asserted for one cycle at beat 6. Required: next cycle m_valid=0, flags 0, frame_count=0, frame_in_ready=1; a new pulse restarts the stream at pixel 0x00 with m_sof=1.
- HEIGHT=1, WIDTH=1, pixel 0xAB. Required: a single beat with m_sof=m_eol=m_eof=1; frame_count increments after that handshake.
